rx_fifo: RTL and testbench

Byte FIFO between the UART receiver and the consuming logic. Captures each received byte on the rising edge of the receiver's done strobe, buffers up to 2^W bytes, and presents the oldest byte show-ahead on its read port until the consumer pops it. This decouples receiver timing from consumer latency so bytes arriving back-to-back at the baud rate are not lost.

---
 rtl/rx_fifo.sv | 96 +++++++++
 tb/tb_rx_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: byte FIFO between the UART receiver and its consumer, show-ahead read port.
// Latency: a wr rising edge stores w_data at the next clk edge; r_data follows rp combinationally.
// Backpressure: none toward the receiver; a write arriving while full without a pop is dropped.
//
// Parameters: B = data width, W = address width (depth 2^W).
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   wr, w_data      receiver done strobe (edge-detected) and its byte
//   rd              pop request, honoured only while not empty
//   r_data          oldest stored byte, valid while empty is 0
//   empty, full     registered occupancy flags
//   ovf             sticky overflow flag, present only when RX_FIFO_OVF_EN is defined
module rx_fifo #(
   parameter int B = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   input  logic         rd,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full
`ifdef RX_FIFO_OVF_EN
  ,output logic         ovf
`endif
);

   localparam int DEPTH = 1 << W;

   logic [B-1:0] mem [DEPTH];
   logic [W-1:0] wp;
   logic [W-1:0] rp;
   logic [W-1:0] wp_inc;
   logic [W-1:0] rp_inc;
   logic         wr_q;
   logic         wr_pulse;
   logic         we;
   logic         re;

   assign wr_pulse = wr & ~wr_q;
   // While full, a write is only accepted if the same cycle frees a slot.
   assign we       = wr_pulse & (~full | rd);
   assign re       = rd & ~empty;
   assign wp_inc   = wp + 1'b1;
   assign rp_inc   = rp + 1'b1;

   assign r_data   = mem[rp];

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (we && !reset) begin
         mem[wp] <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // The strobe keeps being tracked through reset so a wr that is
         // already high when reset releases is not mistaken for a new byte.
         wr_q  <= wr;
         wp    <= '0;
         rp    <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         wr_q <= wr;
         if (we) begin
            wp <= wp_inc;
         end
         if (re) begin
            rp <= rp_inc;
         end
         // Flags only move when exactly one side is active.
         if (we && !re) begin
            empty <= 1'b0;
            full  <= (wp_inc == rp);
         end else if (re && !we) begin
            full  <= 1'b0;
            empty <= (rp_inc == wp);
         end
      end
   end

`ifdef RX_FIFO_OVF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (wr_pulse && full && !rd) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed and random stimulus for rx_fifo against a queue-based reference.
// Latency: checks sample outputs 1 time unit after each rising clk edge.
// Backpressure: the model drops a write when it holds 16 bytes and no pop occurs.
module tb_rx_fifo;

   localparam int B = 8;
   localparam int W = 4;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         wr;
   logic         rd;
   logic [B-1:0] w_data;
   logic [B-1:0] r_data;
   logic         empty;
   logic         full;
`ifdef RX_FIFO_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   // Reference state: contents in arrival order, last seen strobe level, sticky overflow.
   logic [B-1:0] q[$];
   bit           wr_prev;
   bit           ovf_m;

   rx_fifo #(.B(B), .W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr),
      .w_data (w_data),
      .rd     (rd),
      .r_data (r_data),
      .empty  (empty),
      .full   (full)
`ifdef RX_FIFO_OVF_EN
     ,.ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input bit rst, input bit w, input logic [B-1:0] d, input bit r);
      bit pulse;
      bit do_pop;
      bit do_push;
      reset  = rst;
      wr     = w;
      w_data = d;
      rd     = r;
      if (rst) begin
         q.delete();
         wr_prev = w;
         ovf_m   = 1'b0;
      end else begin
         pulse   = w && !wr_prev;
         wr_prev = w;
         do_pop  = r && (q.size() > 0);
         do_push = pulse && ((q.size() < D) || r);
         if (pulse && (q.size() == D) && !r) ovf_m = 1'b1;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      @(posedge clk);
      #1;
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == D));
      if (q.size() > 0) chk("r_data", 32'(r_data), 32'(q[0]));
`ifdef RX_FIFO_OVF_EN
      chk("ovf", 32'(ovf), 32'(ovf_m));
`endif
   endtask

   task automatic pop_exp(input logic [B-1:0] exp);
      chk("pop_head", 32'(r_data), 32'(exp));
      step(1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      bit w_rand;
      reset  = 1'b1;
      wr     = 1'b1;
      rd     = 1'b1;
      w_data = '0;

      // Reset held two cycles with wr and rd high.
      step(1'b1, 1'b1, 8'h99, 1'b1);
      step(1'b1, 1'b1, 8'h99, 1'b1);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      // wr still high after release: no rising edge, so nothing is written.
      step(1'b0, 1'b1, 8'h55, 1'b0);
      chk("no_write_after_reset", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Single byte.
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      chk("single_empty", 32'(empty), 32'd0);
      chk("single_data", 32'(r_data), 32'hA5);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      pop_exp(8'hA5);
      chk("single_popped", 32'(empty), 32'd1);

      // Held strobe writes once.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h3C, 1'b0);
      pop_exp(8'h3C);
      chk("held_one_entry", 32'(empty), 32'd1);

      // Fill, overflow, wrap.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0);
         step(1'b0, 1'b0, 8'h00, 1'b0);
      end
      chk("fill_full", 32'(full), 32'd1);
      step(1'b0, 1'b1, 8'hEE, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("ovf_still_full", 32'(full), 32'd1);
`ifdef RX_FIFO_OVF_EN
      chk("ovf_set", 32'(ovf), 32'd1);
`endif
      for (int i = 0; i < 4; i++) pop_exp(8'(i));
      for (int i = 16; i < 20; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0);
         step(1'b0, 1'b0, 8'h00, 1'b0);
      end
      chk("wrap_full", 32'(full), 32'd1);
      for (int i = 4; i < 20; i++) pop_exp(8'(i));
      chk("wrap_empty", 32'(empty), 32'd1);
`ifdef RX_FIFO_OVF_EN
      chk("ovf_sticky", 32'(ovf), 32'd1);
`endif

      // Simultaneous write and pop on empty: write only.
      step(1'b0, 1'b1, 8'h42, 1'b1);
      chk("sim_empty_stored", 32'(empty), 32'd0);
      chk("sim_empty_data", 32'(r_data), 32'h42);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      pop_exp(8'h42);
      chk("sim_empty_one", 32'(empty), 32'd1);

      // Simultaneous write and pop on full: both happen.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
         step(1'b0, 1'b0, 8'h00, 1'b0);
      end
      step(1'b0, 1'b1, 8'h77, 1'b1);
      chk("sim_full_full", 32'(full), 32'd1);
      chk("sim_full_head", 32'(r_data), 32'h81);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 1; i < 16; i++) pop_exp(8'(8'h80 + i));
      pop_exp(8'h77);
      chk("sim_full_drained", 32'(empty), 32'd1);

      // Random traffic with a reset in the middle.
      w_rand = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) w_rand = ~w_rand;
         step(n == 300, w_rand, 8'($urandom), $urandom_range(0, 3) == 0);
      end
`ifdef RX_FIFO_OVF_EN
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("ovf_cleared", 32'(ovf), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
